// File: rtl/stepper_motor_ctrl_if.sv
// Command channel of the stepper controller: a move request with its options
// (step count, direction, speed mode, half-step) under a valid/ready handshake.
interface stepper_motor_ctrl_if #(
  parameter int POS_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [POS_W-1:0] cmd_steps;
  logic             cmd_dir;
  logic [1:0]       mode;
  logic             half_step;

  modport master (output cmd_valid, cmd_steps, cmd_dir, mode, half_step,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_steps, cmd_dir, mode, half_step,
                  output cmd_ready);
endinterface

// File: rtl/stepper_motor_ctrl.sv
// Single-channel 4-coil stepper controller with full/half-step sequencing and tick pacing.
// Define STEPPER_HOLD_EN to keep the last phase energised in IDLE (holding torque).
module stepper_motor_ctrl #(
  parameter int CNT_W  = 26,
  parameter int POS_W  = 16,
  parameter int SPEED0 = 300000,
  parameter int SPEED1 = 200000,
  parameter int SPEED2 = 150000,
  parameter int SPEED3 = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  stepper_motor_ctrl_if.slave     cmd,
  input  logic                    abort,
  output logic [3:0]              coil,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]              state;
  logic [2:0]              idx;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        period;
  logic [POS_W-1:0]        remaining;
  logic                    dir_q;
  logic                    half_q;

  logic [CNT_W-1:0]        speed_sel;
  logic [2:0]              step_mag;
  logic [2:0]              next_idx;
  logic signed [POS_W-1:0] pos_delta;
  logic                    tick;
  logic                    accept;

  function automatic logic [3:0] phase_pattern(input logic [2:0] i);
    case (i)
      3'd0: return 4'b0001;
      3'd1: return 4'b0011;
      3'd2: return 4'b0010;
      3'd3: return 4'b0110;
      3'd4: return 4'b0100;
      3'd5: return 4'b1100;
      3'd6: return 4'b1000;
      3'd7: return 4'b1001;
    endcase
  endfunction

  // NOTE: give every combinational output a default before the case so no latch is inferred.
  always_comb begin
    speed_sel = CNT_W'(SPEED0);
    case (cmd.mode)
      2'd1:    speed_sel = CNT_W'(SPEED1);
      2'd2:    speed_sel = CNT_W'(SPEED2);
      2'd3:    speed_sel = CNT_W'(SPEED3);
      default: speed_sel = CNT_W'(SPEED0);
    endcase
  end

  // Full step moves two table entries, so an odd index stays on the two-coil patterns.
  assign step_mag  = half_q ? 3'd1 : 3'd2;
  assign next_idx  = dir_q ? idx + step_mag : idx - step_mag;
  assign pos_delta = dir_q ? POS_W'(step_mag) : -POS_W'(step_mag);

  assign tick          = (cnt == period - CNT_W'(1));
  assign accept        = cmd.cmd_valid && (state == IDLE);
  assign busy          = (state == RUN);
  assign cmd.cmd_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      period    <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      coil      <= 4'b0000;
      done      <= 1'b0;
      position  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd.cmd_steps != '0) begin
              dir_q     <= cmd.cmd_dir;
              half_q    <= cmd.half_step;
              period    <= speed_sel;
              remaining <= cmd.cmd_steps;
              cnt       <= '0;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // Abort outranks a tick landing on the same cycle.
          if (abort) begin
            state     <= IDLE;
            done      <= 1'b1;
            remaining <= '0;
`ifndef STEPPER_HOLD_EN
            coil      <= 4'b0000;
`endif
          end else if (tick) begin
            cnt       <= '0;
            idx       <= next_idx;
            position  <= position + pos_delta;
            remaining <= remaining - POS_W'(1);
            if (remaining == POS_W'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
`ifdef STEPPER_HOLD_EN
              coil  <= phase_pattern(next_idx);
`else
              coil  <= 4'b0000;
`endif
            end else begin
              coil <= phase_pattern(next_idx);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_motor_ctrl.sv
// Self-checking bench for stepper_motor_ctrl: directed scenarios plus randomised moves
// checked against an arithmetic position/phase model.
module tb_stepper_motor_ctrl;

  localparam int SP0 = 10;
  localparam int SP1 = 7;
  localparam int SP2 = 5;
  localparam int SP3 = 3;
`ifdef STEPPER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stepper_motor_ctrl_if #(.POS_W(16)) cif ();
  logic        abort;
  logic [3:0]  coil;
  logic        busy;
  logic        done;
  logic [15:0] position;

  stepper_motor_ctrl #(
    .CNT_W(26), .POS_W(16), .SPEED0(SP0), .SPEED1(SP1), .SPEED2(SP2), .SPEED3(SP3)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cif), .abort(abort),
    .coil(coil), .busy(busy), .done(done), .position(position)
  );

  // Narrow-position instance for the wrap scenario.
  stepper_motor_ctrl_if #(.POS_W(4)) wif ();
  logic       abort_w;
  logic [3:0] coil_w;
  logic       busy_w;
  logic       done_w;
  logic [3:0] pos_w;

  stepper_motor_ctrl #(
    .CNT_W(26), .POS_W(4), .SPEED0(SP0), .SPEED1(SP1), .SPEED2(SP2), .SPEED3(SP3)
  ) dut_w (
    .clk(clk), .rst(rst), .cmd(wif), .abort(abort_w),
    .coil(coil_w), .busy(busy_w), .done(done_w), .position(pos_w)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};
  int         m_idx;
  int         m_pos;
  logic [3:0] m_coil;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one command and follows it cycle by cycle; abort_tick>0 asserts abort
  // on the cycle whose closing edge would carry that tick.
  task automatic run_move(input int steps, input bit dir, input bit hs,
                          input logic [1:0] md, input int abort_tick, input bit wiggle);
    int per, inc, last;
    per = (md == 2'd0) ? SP0 : (md == 2'd1) ? SP1 : (md == 2'd2) ? SP2 : SP3;
    inc = (hs ? 1 : 2) * (dir ? 1 : -1);
    check("ready_before", 32'(cif.cmd_ready), 32'd1);
    cif.cmd_valid = 1'b1;
    cif.cmd_steps = 16'(steps);
    cif.cmd_dir   = dir;
    cif.mode      = md;
    cif.half_step = hs;
    cyc();
    cif.cmd_valid = 1'b0;
    if (steps == 0) begin
      check("zero_done",  32'(done), 32'd1);
      check("zero_busy",  32'(busy), 32'd0);
      check("zero_coil",  32'(coil), 32'(m_coil));
      check("zero_pos",   32'(position), 32'(16'(m_pos)));
      cyc();
      check("zero_done_clr", 32'(done), 32'd0);
      return;
    end
    check("run_ready", 32'(cif.cmd_ready), 32'd0);
    last = (abort_tick > 0) ? abort_tick * per : steps * per;
    for (int c = 1; c <= last; c++) begin
      if (wiggle) begin
        cif.mode      = 2'($urandom);
        cif.half_step = 1'($urandom);
        cif.cmd_dir   = 1'($urandom);
        cif.cmd_steps = 16'($urandom);
        cif.cmd_valid = 1'($urandom);
      end
      if (abort_tick > 0 && c == last) abort = 1'b1;
      cyc();
      abort = 1'b0;
      cif.cmd_valid = 1'b0;
      if (abort_tick > 0 && c == last) begin
        if (!HOLD) m_coil = 4'b0000;
      end else if (c % per == 0) begin
        m_idx  = ((m_idx + inc) % 8 + 8) % 8;
        m_pos  = m_pos + inc;
        m_coil = (c == last && !HOLD) ? 4'b0000 : tbl[m_idx];
      end
      if (c == last) begin
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd1);
        check("end_coil", 32'(coil), 32'(m_coil));
        check("end_pos",  32'(position), 32'(16'(m_pos)));
      end else begin
        check("run_busy", 32'(busy), 32'd1);
        check("run_coil", 32'(coil), 32'(m_coil));
        check("run_done", 32'(done), 32'd0);
      end
    end
    cyc();
    check("after_done", 32'(done), 32'd0);
    check("after_ready", 32'(cif.cmd_ready), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int steps, ab;
    bit dir, hs;
    logic [1:0] md;

    rst = 1'b1;
    abort = 1'b0;
    abort_w = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_steps = '0; cif.cmd_dir = 1'b0; cif.mode = '0; cif.half_step = 1'b0;
    wif.cmd_valid = 1'b0; wif.cmd_steps = '0; wif.cmd_dir = 1'b0; wif.mode = '0; wif.half_step = 1'b0;
    m_idx = 0; m_pos = 0; m_coil = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc();
    check("rst_coil",  32'(coil), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ready", 32'(cif.cmd_ready), 32'd1);
    check("rst_pos",   32'(position), 32'd0);

    // Forward full step: 0010, 0100, 1000, 0001 ten cycles apart, position 8.
    run_move(4, 1'b1, 1'b0, 2'd0, 0, 1'b0);
    check("fwd_pos", 32'(position), 32'd8);
    check("fwd_hold", 32'(coil), HOLD ? 32'b0001 : 32'd0);

    // Reverse half step from index 0: 1001, 1000, 1100, position 5.
    run_move(3, 1'b0, 1'b1, 2'd0, 0, 1'b0);
    check("rev_pos", 32'(position), 32'd5);
    check("rev_hold", 32'(coil), HOLD ? 32'b1100 : 32'd0);

    run_move(0, 1'b1, 1'b0, 2'd0, 0, 1'b0);

    // Abort in IDLE must do nothing.
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_done", 32'(done), 32'd0);
    check("idle_abort_coil", 32'(coil), 32'(m_coil));

    // Abort on the cycle of the third tick: two steps only (5 + 2*2 = 9).
    run_move(100, 1'b1, 1'b0, 2'd0, 3, 1'b0);
    check("abort_pos", 32'(position), 32'd9);

    // Position wrap on the 4-bit instance: +9 half steps gives 4'b1001.
    wif.cmd_valid = 1'b1; wif.cmd_steps = 4'd9; wif.cmd_dir = 1'b1; wif.half_step = 1'b1; wif.mode = 2'd0;
    cyc();
    wif.cmd_valid = 1'b0;
    repeat (90) cyc();
    check("wrap_pos",  32'(pos_w), 32'b1001);
    check("wrap_busy", 32'(busy_w), 32'd0);
    check("wrap_done", 32'(done_w), 32'd1);

    for (int i = 0; i < 12; i++) begin
      steps = $urandom_range(0, 6);
      dir   = 1'($urandom);
      hs    = 1'($urandom);
      md    = 2'($urandom);
      ab    = (steps > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, steps) : 0;
      run_move(steps, dir, hs, md, ab, 1'b1);
    end

    // Asynchronous reset in the middle of a move, sampled before any clock edge.
    cif.cmd_valid = 1'b1; cif.cmd_steps = 16'd50; cif.cmd_dir = 1'b1; cif.half_step = 1'b1; cif.mode = 2'd0;
    cyc();
    cif.cmd_valid = 1'b0;
    repeat (25) cyc();
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_coil",  32'(coil), 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_done",  32'(done), 32'd0);
    check("arst_ready", 32'(cif.cmd_ready), 32'd1);
    check("arst_pos",   32'(position), 32'd0);
    #2 rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
